data_plane_rx_ctrl: RTL and testbench

Controller for the data-plane receive buffer. Filters incoming data-plane flits by destination node ID and counts fixed-length bursts. It arbitrates the single-port receive stack RAM between network writes and GPP pop requests, and tracks the stack pointer with full/empty protection. It sits between the data-plane link and the receive `Data_Memory` instance, and drives the completion flag back to the control plane.

---
 rtl/data_plane_rx_ctrl_if.sv | 26 ++
 rtl/data_plane_rx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_plane_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_plane_rx_ctrl_if.sv
// rtl/data_plane_rx_ctrl_if.sv - receive stack RAM port and GPP pop handshake bundle
interface data_plane_rx_ctrl_if #(
    parameter int AW = 4
);
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          gpp_pop;
    logic          pop_ack;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output pop_ack,
        input  gpp_pop
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  pop_ack,
        output gpp_pop
    );
endinterface

// File: rtl/data_plane_rx_ctrl.sv
// rtl/data_plane_rx_ctrl.sv - data-plane rx filter, burst counter and stack arbiter
// Optional burst timeout abort is enabled by defining RX_TIMEOUT_EN.
module data_plane_rx_ctrl #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BURST_LEN = 5,
    parameter int TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_rx_packet,
    input  logic [15:0]           node_id,
    data_plane_rx_ctrl_if.master  bus,
    output logic                  pop_empty_err,
    output logic                  data_rx_complete_flag,
    output logic                  rx_abort,
    output logic                  overflow,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           sp
);
    localparam int CW = $clog2(BURST_LEN + 1);

    generate
        if (((1 << AW) != DEPTH) || (BURST_LEN > DEPTH) || (BURST_LEN < 2) || (TIMEOUT < 1)) begin : g_bad_cfg
            $error("data_plane_rx_ctrl: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          flit_v;
    logic [15:0]   flit_q;
    logic          wr_en;
    logic          pop_go;
    logic [AW:0]   sp_dec;
    logic [AW:0]   sp_step;
    logic [AW:0]   sp_next;
    logic          abort_hit;

    // Write has absolute priority; a pop only proceeds in a cycle without a write.
    always_comb begin
        wr_en         = flit_v && !full;
        pop_go        = bus.gpp_pop && !wr_en;
        sp_dec        = sp - 1'b1;
        bus.ram_we    = wr_en;
        bus.pop_ack   = pop_go;
        bus.ram_wdata = flit_q;
        if (wr_en) begin
            bus.ram_addr = sp[AW-1:0];
        end else if (empty) begin
            bus.ram_addr = '0;
        end else begin
            bus.ram_addr = sp_dec[AW-1:0];
        end
        if (wr_en) begin
            sp_step = sp + 1'b1;
        end else if (pop_go && !empty) begin
            sp_step = sp_dec;
        end else begin
            sp_step = sp;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic [AW:0]   base;

    always_comb begin
        abort_hit = (state == RECV) && !flit_v && (timer == TW'(TIMEOUT - 1));
        sp_next   = sp_step;
        // Abort rolls back to the burst start, but never above a level a pop already took it below.
        if (abort_hit && (sp_step > base)) begin
            sp_next = base;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            base     <= '0;
            rx_abort <= 1'b0;
        end else begin
            rx_abort <= abort_hit;
            if (state != RECV || flit_v || abort_hit) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (flit_v && state != RECV) begin
                base <= sp;
            end
        end
    end
`else
    always_comb begin
        abort_hit = 1'b0;
        sp_next   = sp_step;
    end

    assign rx_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            cnt                   <= '0;
            flit_v                <= 1'b0;
            flit_q                <= '0;
            sp                    <= '0;
            full                  <= 1'b0;
            empty                 <= 1'b1;
            overflow              <= 1'b0;
            pop_empty_err         <= 1'b0;
            data_rx_complete_flag <= 1'b0;
        end else begin
            flit_v        <= (data_rx_packet[31:16] == node_id);
            flit_q        <= data_rx_packet[15:0];
            sp            <= sp_next;
            full          <= (sp_next == (AW+1)'(DEPTH));
            empty         <= (sp_next == '0);
            pop_empty_err <= pop_go && empty;
            if (flit_v && full) begin
                overflow <= 1'b1;
            end
            data_rx_complete_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (flit_v) begin
                        state <= RECV;
                        cnt   <= CW'(1);
                    end
                end
                RECV: begin
                    if (flit_v) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(BURST_LEN - 1)) begin
                            state                 <= DONE;
                            data_rx_complete_flag <= 1'b1;
                        end
                    end else if (abort_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                DONE: begin
                    if (flit_v) begin
                        state <= RECV;
                        cnt   <= CW'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_plane_rx_ctrl.sv
// tb/tb_data_plane_rx_ctrl.sv - self-checking bench for data_plane_rx_ctrl
module tb_data_plane_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BL    = 5;
    localparam logic [15:0] NODE = 16'h0042;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pkt = '0;
    logic [15:0] node_id = NODE;
    logic        pop_empty_err, data_rx_complete_flag, rx_abort, overflow, full, empty;
    logic [AW:0] sp;

    data_plane_rx_ctrl_if #(.AW(AW)) bus ();

    data_plane_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .BURST_LEN(BL), .TIMEOUT(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_rx_packet        (pkt),
        .node_id               (node_id),
        .bus                   (bus.master),
        .pop_empty_err         (pop_empty_err),
        .data_rx_complete_flag (data_rx_complete_flag),
        .rx_abort              (rx_abort),
        .overflow              (overflow),
        .full                  (full),
        .empty                 (empty),
        .sp                    (sp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: stack contents as a queue, burst completion as a running flit count mod BL.
    logic        m_pv = 1'b0;
    logic [15:0] m_pd = '0;
    logic [15:0] m_stk[$];
    int          m_flits = 0;
    bit          m_flag = 0, m_err = 0, m_ovf = 0;
    bit          model_on = 1;

    int wr_log[$];
    int ack_log[$];
    int ack_steps[$];
    int n_flag = 0, n_err = 0, n_abort = 0, step_no = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fm(input logic [15:0] d);
        return {NODE, d};
    endfunction

    function automatic logic [31:0] fx(input logic [15:0] d);
        return {16'h0043, d};
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        ack_log.delete();
        ack_steps.delete();
        n_flag = 0;
        n_err = 0;
        n_abort = 0;
    endtask

    task automatic step(input logic [31:0] p, input logic pop);
        int sz;
        bit exp_we, exp_ack;
        int exp_addr;
        pkt = p;
        bus.gpp_pop = pop;
        #1;
        sz       = m_stk.size();
        exp_we   = m_pv && (sz < DEPTH);
        exp_ack  = pop && !exp_we;
        exp_addr = exp_we ? sz : ((sz == 0) ? 0 : sz - 1);
        if (model_on) begin
            chk("ram_we", bus.ram_we, exp_we);
            chk("ram_addr", bus.ram_addr, exp_addr);
            chk("pop_ack", bus.pop_ack, exp_ack);
            if (exp_we) chk("ram_wdata", bus.ram_wdata, m_pd);
            chk("sp", sp, sz);
            chk("full", full, sz == DEPTH);
            chk("empty", empty, sz == 0);
            chk("complete_flag", data_rx_complete_flag, m_flag);
            chk("pop_empty_err", pop_empty_err, m_err);
            chk("overflow", overflow, m_ovf);
            chk("rx_abort", rx_abort, 0);
        end
        if (bus.ram_we) wr_log.push_back(int'(bus.ram_addr));
        if (bus.pop_ack) begin
            ack_log.push_back(int'(bus.ram_addr));
            ack_steps.push_back(step_no);
        end
        if (data_rx_complete_flag) n_flag++;
        if (pop_empty_err) n_err++;
        if (rx_abort) n_abort++;
        @(posedge clk);
        m_err = exp_ack && (sz == 0);
        if (exp_we) m_stk.push_back(m_pd);
        else if (m_pv) m_ovf = 1;
        if (exp_ack && sz > 0) void'(m_stk.pop_back());
        m_flag = 0;
        if (m_pv) begin
            m_flits++;
            m_flag = (m_flits % BL) == 0;
        end
        m_pv = (p[31:16] == NODE);
        m_pd = p[15:0];
        step_no++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pkt = '0;
        bus.gpp_pop = 1'b0;
        #1;
        m_stk.delete();
        m_pv = 0; m_pd = '0; m_flits = 0; m_flag = 0; m_err = 0; m_ovf = 0;
        chk("rst_sp", sp, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_flag", data_rx_complete_flag, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err", pop_empty_err, 0);
        chk("rst_abort", rx_abort, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_pop_ack", bus.pop_ack, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.gpp_pop = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Clean burst 0xA0..0xA4
        clear_logs();
        for (int i = 0; i < 5; i++) step(fm(16'h00A0 + 16'(i)), 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        chk("b1_writes", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("b1_addr", wr_log[i], i);
        chk("b1_flags", n_flag, 1);
        chk("b1_sp", sp, 5);

        // Three pops
        clear_logs();
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        step('0, 1'b0);
        chk("pop_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("pop_addr0", ack_log[0], 4);
            chk("pop_addr1", ack_log[1], 3);
            chk("pop_addr2", ack_log[2], 2);
        end
        chk("pop_sp", sp, 2);

        // Burst with interleaved foreign flits
        clear_logs();
        step(fm(16'h00B0), 1'b0); step(fx(16'h0001), 1'b0);
        step(fm(16'h00B1), 1'b0); step(fx(16'h0002), 1'b0);
        step(fm(16'h00B2), 1'b0); step(fx(16'h0003), 1'b0);
        step(fm(16'h00B3), 1'b0); step(fm(16'h00B4), 1'b0);
        step('0, 1'b0);
        chk("b2_flags_early", n_flag, 0);
        step('0, 1'b0);
        chk("b2_writes", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("b2_addr", wr_log[i], 2 + i);
        chk("b2_flags", n_flag, 1);
        chk("b2_sp", sp, 7);

        // Pop held against a stream of writes
        clear_logs();
        begin
            int s0;
            s0 = step_no;
            step(fm(16'h00C0), 1'b0);
            step(fm(16'h00C1), 1'b1);
            step(fm(16'h00C2), 1'b1);
            step('0, 1'b1);
            step('0, 1'b1);
            step('0, 1'b0);
            chk("held_ack_count", ack_steps.size(), 1);
            if (ack_steps.size() == 1) chk("held_ack_step", ack_steps[0] - s0, 4);
            chk("held_sp", sp, 9);
        end

        // Overflow, sticky flag, drain, empty pop
        do_reset();
        clear_logs();
        for (int i = 0; i < 20; i++) step(fm(16'h0100 + 16'(i)), 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        chk("ovf_writes", wr_log.size(), 16);
        chk("ovf_flags", n_flag, 4);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) step('0, 1'b1);
        step('0, 1'b0);
        chk("drain_sp", sp, 0);
        chk("drain_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);
        clear_logs();
        step('0, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);
        chk("empty_pop_ack", ack_log.size(), 1);
        chk("empty_err_pulses", n_err, 1);
        chk("empty_sp", sp, 0);

        // Reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 3; i++) step(fm(16'h00D0 + 16'(i)), 1'b0);
        do_reset();
        clear_logs();
        for (int i = 0; i < 5; i++) step(fm(16'h00E0 + 16'(i)), 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        chk("rb_writes", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("rb_addr", wr_log[i], i);
        chk("rb_flags", n_flag, 1);
        chk("rb_sp", sp, 5);

`ifdef RX_TIMEOUT_EN
        do_reset();
        model_on = 0;
        clear_logs();
        step(fm(16'h00F0), 1'b0);
        step(fm(16'h00F1), 1'b0);
        for (int i = 0; i < 40; i++) step('0, 1'b0);
        chk("to_aborts", n_abort, 1);
        chk("to_sp", sp, 0);
        chk("to_flags", n_flag, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
